// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt datapath: block geometry, byte slicing and FSM states.
package aes_dec_pkg;

    localparam int BLOCK_W = 128;
    localparam int BYTE_W  = 8;
    localparam int NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte 0 is the most significant byte of the block.
    function automatic int byte_lsb(input int i);
        return BLOCK_W - BYTE_W * (i + 1);
    endfunction

endpackage

// File: rtl/desbox.sv
// Combinational AES inverse S-box: c = InvSbox(a).
module desbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    // Entry 0 sits in the top byte, so index 255-a (= ~a) selects entry a.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign c = INV_SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/inv_subbytes_unit.sv
// Iterative InvSubBytes: substitutes LANES bytes per cycle, NCHUNK cycles per 128-bit block.
// IDLE: waiting for a block | BUSY: substituting chunk r_cnt | DONE: result held until out_ready
module inv_subbytes_unit
    import aes_dec_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NCHUNK = NBYTES / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [BLOCK_W-1:0]   r_data;
    logic [BLOCK_W-1:0]   w_data_upd;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_last;
    int                   w_base;
    logic [BYTE_W-1:0]    w_lane_in  [LANES];
    logic [BYTE_W-1:0]    w_lane_out [LANES];

    assign w_base   = int'(r_cnt) * LANES;
    assign w_last   = (r_cnt == CW'(NCHUNK - 1));
    assign w_accept = in_valid & w_in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lane_in[g] = r_data[byte_lsb(w_base + g) +: BYTE_W];
        desbox u_desbox (
            .a (w_lane_in[g]),
            .c (w_lane_out[g])
        );
    end

    always_comb begin
        w_data_upd = r_data;
        for (int l = 0; l < LANES; l++) begin
            w_data_upd[byte_lsb(w_base + l) +: BYTE_W] = w_lane_out[l];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_in_ready  = 1'b1;
                    w_state_nxt = in_valid ? BUSY : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= state_in;
                r_cnt  <= '0;
            end else if (r_state == BUSY) begin
                r_data <= w_data_upd;
                // Wrap on the last chunk so the lane index never leaves the block.
                r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == BUSY);
    assign state_out = out_valid ? r_data : '0;

endmodule
